// File: rtl/cpu_control.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_control
//  Description : Multi-cycle control sequencer for the 16-bit CPU. Fetches
//                and decodes instructions, owns the PC, drives the ALU
//                state/op buses, register-file controls and the req/ack
//                handshakes towards instruction and data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_control #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [2:0]  state,
    output logic [3:0]  alu_op,
    input  logic        compare,
    output logic [15:0] pc,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    output logic [3:0]  rf_waddr,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [15:0] imm,
    output logic        halted
);

    // Sequencer states; the encoding is visible to the ALU on the state bus.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEMORY    = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_HALT      = 3'b101
    } state_t;

    // Opcodes outside the plain ALU range 0..8.
    localparam logic [3:0] OP_ALU_LAST = 4'd8;
    localparam logic [3:0] OP_LOAD     = 4'd9;
    localparam logic [3:0] OP_STORE    = 4'd10;
    localparam logic [3:0] OP_BEQ      = 4'd11;
    localparam logic [3:0] OP_JMP      = 4'd12;
    localparam logic [3:0] OP_LDI      = 4'd13;
    localparam logic [3:0] OP_NOP      = 4'd14;
    localparam logic [3:0] OP_HALT     = 4'd15;

    // ALU codes used for non-ALU instructions.
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_PASS_A  = 4'd7;

    // Write-back source select values.
    localparam logic [1:0] WB_ALU      = 2'd0;
    localparam logic [1:0] WB_MEM      = 2'd1;
    localparam logic [1:0] WB_IMM      = 2'd2;

    state_t      cur_state;
    logic [15:0] ir;

    // Instruction field decode.
    logic [3:0]  opcode;
    logic        is_alu;
    logic        is_load;
    logic        is_store;
    logic        is_beq;
    logic        is_jmp;
    logic        is_ldi;
    logic        is_nop;
    logic        is_halt;
    logic        is_mem;
    logic        is_rf_write;

    // Candidate next-PC values, all modulo 2^16.
    logic [15:0] pc_inc;
    logic [15:0] branch_off;
    logic [15:0] pc_branch;
    logic [15:0] pc_jump;

    assign opcode      = ir[15:12];
    assign is_alu      = (opcode <= OP_ALU_LAST);
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign is_beq      = (opcode == OP_BEQ);
    assign is_jmp      = (opcode == OP_JMP);
    assign is_ldi      = (opcode == OP_LDI);
    assign is_nop      = (opcode == OP_NOP);
    assign is_halt     = (opcode == OP_HALT);
    assign is_mem      = is_load | is_store;
    assign is_rf_write = is_alu | is_load | is_ldi;

    assign pc_inc      = pc + 16'd1;
    assign branch_off  = {{12{ir[3]}}, ir[3:0]};
    assign pc_branch   = pc_inc + branch_off;
    assign pc_jump     = {pc[15:12], ir[11:0]};

    // Sequencer: state transitions, instruction register capture and PC update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_FETCH;
            pc        <= PC_RESET;
            ir        <= 16'h0000;
        end else begin
            case (cur_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir        <= imem_data;
                        cur_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_halt) begin
                        cur_state <= ST_HALT;
                    end else if (is_jmp) begin
                        pc        <= pc_jump;
                        cur_state <= ST_FETCH;
                    end else if (is_nop) begin
                        pc        <= pc_inc;
                        cur_state <= ST_FETCH;
                    end else if (is_ldi) begin
                        cur_state <= ST_WRITEBACK;
                    end else begin
                        cur_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (is_mem) begin
                        cur_state <= ST_MEMORY;
                    end else begin
                        cur_state <= ST_WRITEBACK;
                    end
                end
                ST_MEMORY: begin
                    if (dmem_ack) begin
                        if (is_store) begin
                            // A store has nothing to write back; retire here.
                            pc        <= pc_inc;
                            cur_state <= ST_FETCH;
                        end else begin
                            cur_state <= ST_WRITEBACK;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // The ALU compare flag was registered at the end of EXECUTE.
                    if (is_beq && compare) begin
                        pc <= pc_branch;
                    end else begin
                        pc <= pc_inc;
                    end
                    cur_state <= ST_FETCH;
                end
                ST_HALT: begin
                    cur_state <= ST_HALT;
                end
                default: begin
                    cur_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign state = cur_state;

    // Output decode from the current state and the instruction register.
    always_comb begin
        alu_op    = 4'd0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        halted    = 1'b0;
        rf_raddr1 = ir[7:4];
        rf_raddr2 = ir[3:0];
        rf_waddr  = ir[11:8];
        imm       = {8'h00, ir[7:0]};

        // BEQ compares rd/rs1 against rs1/rs2; STORE reads its data register.
        if (is_beq) begin
            rf_raddr1 = ir[11:8];
            rf_raddr2 = ir[7:4];
        end else if (is_store) begin
            rf_raddr2 = ir[11:8];
        end

        if (is_load) begin
            wb_sel = WB_MEM;
        end else if (is_ldi) begin
            wb_sel = WB_IMM;
        end

        case (cur_state)
            ST_FETCH: begin
                imem_req = 1'b1;
            end
            ST_DECODE, ST_EXECUTE: begin
                if (is_alu) begin
                    alu_op = opcode;
                end else if (is_mem) begin
                    alu_op = ALU_PASS_A;
                end else if (is_beq) begin
                    alu_op = ALU_SUB;
                end
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            ST_WRITEBACK: begin
                rf_we = is_rf_write;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_control
//  Description : Self-checking bench for cpu_control. Acts as instruction
//                and data memory with random wait states and compares the
//                observed control sequence against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control;

    localparam logic [15:0] RST_PC = 16'hFFF8;

    logic        clk;
    logic        rst_n;
    logic [2:0]  state;
    logic [3:0]  alu_op;
    logic        compare;
    logic [15:0] pc;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [3:0]  rf_waddr;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [15:0] imm;
    logic        halted;

    int          errors;
    int          checks;
    logic [15:0] pc_model;

    cpu_control #(.PC_RESET(RST_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .alu_op    (alu_op),
        .compare   (compare),
        .pc        (pc),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_waddr  (rf_waddr),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .imm       (imm),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        dmem_ack  = 1'b0;
        compare   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state",    32'(state),    32'd0);
        chk("rst_pc",       32'(pc),       32'(RST_PC));
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_halted",   32'(halted),   32'd0);
        chk("rst_alu_op",   32'(alu_op),   32'd0);
        rst_n    = 1'b1;
        pc_model = RST_PC;
    endtask

    // Executes one instruction with iw fetch wait cycles and dw data wait
    // cycles; called on a falling edge while the DUT sits in FETCH.
    task automatic run_instr(input logic [15:0] instr, input int iw, input int dw, input logic cmpv);
        logic [3:0]  op;
        logic        alu_class;
        logic        has_exec;
        logic        has_mem;
        logic        has_wb;
        logic        writes;
        logic [1:0]  want_sel;
        logic [3:0]  want_alu;
        logic [15:0] next_pc;
        logic [2:0]  q[$];
        int          fc;
        int          mc;
        int          n_ireq;
        int          n_dreq;
        int          n_dwe;
        int          n_we;
        logic [3:0]  seen_waddr;
        logic [1:0]  seen_sel;
        logic [15:0] seen_imm;
        logic [3:0]  seen_alu_d;
        logic [3:0]  seen_alu_e;
        logic [3:0]  seen_r1;
        logic [3:0]  seen_r2;
        logic        pair_ok;

        op        = instr[15:12];
        alu_class = (op <= 4'd8);
        has_exec  = alu_class || op == 4'd9 || op == 4'd10 || op == 4'd11;
        has_mem   = (op == 4'd9) || (op == 4'd10);
        has_wb    = alu_class || op == 4'd9 || op == 4'd11 || op == 4'd13;
        writes    = alu_class || op == 4'd9 || op == 4'd13;
        want_sel  = (op == 4'd9) ? 2'd1 : ((op == 4'd13) ? 2'd2 : 2'd0);
        want_alu  = alu_class ? op : ((op == 4'd11) ? 4'd1 : 4'd7);

        case (op)
            4'd12:   next_pc = {pc_model[15:12], instr[11:0]};
            4'd15:   next_pc = pc_model;
            4'd11:   next_pc = cmpv ? (pc_model + 16'd1 + {{12{instr[3]}}, instr[3:0]})
                                    : (pc_model + 16'd1);
            default: next_pc = pc_model + 16'd1;
        endcase

        for (int i = 0; i <= iw; i++) q.push_back(3'd0);
        q.push_back(3'd1);
        if (has_exec) q.push_back(3'd2);
        if (has_mem) for (int i = 0; i <= dw; i++) q.push_back(3'd3);
        if (has_wb) q.push_back(3'd4);

        fc = 0; mc = 0; n_ireq = 0; n_dreq = 0; n_dwe = 0; n_we = 0;
        seen_waddr = '0; seen_sel = '0; seen_imm = '0;
        seen_alu_d = '0; seen_alu_e = '0; seen_r1 = '0; seen_r2 = '0;
        compare = cmpv;

        for (int k = 0; k < q.size(); k++) begin
            chk("state_seq", 32'(state), 32'(q[k]));
            if (imem_req) n_ireq++;
            if (dmem_req) begin
                n_dreq++;
                if (dmem_we) n_dwe++;
            end
            if (rf_we) begin
                n_we++;
                seen_waddr = rf_waddr;
                seen_sel   = wb_sel;
                seen_imm   = imm;
            end
            if (state == 3'd1) begin
                seen_alu_d = alu_op;
                seen_r1    = rf_raddr1;
                seen_r2    = rf_raddr2;
            end
            if (state == 3'd2) seen_alu_e = alu_op;

            // Garbage on imem while not acknowledging; stray acks outside FETCH.
            if (state == 3'd0) begin
                imem_ack  = (fc == iw);
                imem_data = (fc == iw) ? instr : 16'($urandom);
                fc++;
            end else begin
                imem_ack  = 1'($urandom);
                imem_data = 16'($urandom);
            end
            dmem_ack = 1'b0;
            if (state == 3'd3) begin
                dmem_ack = (mc == dw);
                mc++;
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        chk("end_state", 32'(state), (op == 4'd15) ? 32'd5 : 32'd0);
        chk("pc",        32'(pc),    32'(next_pc));
        chk("imem_req_cycles", 32'(n_ireq), 32'(iw + 1));
        chk("dmem_req_cycles", 32'(n_dreq), has_mem ? 32'(dw + 1) : 32'd0);
        chk("dmem_we_cycles",  32'(n_dwe),  (op == 4'd10) ? 32'(dw + 1) : 32'd0);
        chk("rf_we_cycles",    32'(n_we),   writes ? 32'd1 : 32'd0);
        if (writes) begin
            chk("rf_waddr", 32'(seen_waddr), 32'(instr[11:8]));
            chk("wb_sel",   32'(seen_sel),   32'(want_sel));
        end
        if (op == 4'd13) chk("imm", 32'(seen_imm), {24'h0, instr[7:0]});
        if (has_exec) begin
            chk("alu_op_decode",  32'(seen_alu_d), 32'(want_alu));
            chk("alu_op_execute", 32'(seen_alu_e), 32'(want_alu));
        end
        if (alu_class || has_mem) chk("rf_raddr1", 32'(seen_r1), 32'(instr[7:4]));
        if (alu_class) chk("rf_raddr2", 32'(seen_r2), 32'(instr[3:0]));
        if (op == 4'd11) begin
            pair_ok = (seen_r1 == instr[11:8] && seen_r2 == instr[7:4]) ||
                      (seen_r1 == instr[7:4]  && seen_r2 == instr[11:8]);
            chk("beq_raddr_pair", 32'(pair_ok), 32'd1);
        end
        pc_model = next_pc;
    endtask

    initial begin
        logic [3:0] rop;
        errors = 0;
        checks = 0;
        do_reset();

        // Directed: basic ALU op, delayed fetch, jumps, PC wrap, branches.
        run_instr(16'h0123, 0, 0, 1'b0);
        run_instr(16'h0123, 3, 0, 1'b0);
        run_instr(16'hCABC, 0, 0, 1'b0);
        run_instr(16'hCFFF, 0, 0, 1'b0);
        run_instr(16'hE000, 0, 0, 1'b0);
        chk("nop_wrap_pc", 32'(pc), 32'd0);
        run_instr(16'hC005, 0, 0, 1'b0);
        run_instr(16'hB12E, 0, 0, 1'b1);
        chk("beq_taken_pc", 32'(pc), 32'h4);
        run_instr(16'hC005, 0, 0, 1'b0);
        run_instr(16'hB12E, 0, 0, 1'b0);
        chk("beq_not_taken_pc", 32'(pc), 32'h6);
        run_instr(16'h9340, 0, 2, 1'b0);
        run_instr(16'hA340, 1, 0, 1'b0);
        run_instr(16'hD05A, 0, 0, 1'b0);
        run_instr(16'hC000, 0, 0, 1'b0);
        run_instr(16'hB008, 0, 0, 1'b1);
        chk("beq_backward_wrap_pc", 32'(pc), 32'hFFF9);

        // Random instruction stream (no HALT) with random waits and flags.
        for (int n = 0; n < 200; n++) begin
            rop = 4'($urandom_range(0, 14));
            run_instr({rop, 12'($urandom)}, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom));
        end

        // HALT is absorbing and ignores fetch acknowledges.
        run_instr(16'hF000, 1, 0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            imem_ack  = 1'($urandom);
            imem_data = 16'($urandom);
            chk("halt_state",    32'(state),    32'd5);
            chk("halt_halted",   32'(halted),   32'd1);
            chk("halt_imem_req", 32'(imem_req), 32'd0);
            chk("halt_pc",       32'(pc),       32'(pc_model));
            @(negedge clk);
        end
        do_reset();

        // Asynchronous reset in the middle of a data access.
        imem_ack  = 1'b1;
        imem_data = 16'h9340;
        dmem_ack  = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("mid_decode", 32'(state), 32'd1);
        @(negedge clk);
        chk("mid_execute", 32'(state), 32'd2);
        @(negedge clk);
        chk("mid_memory", 32'(state), 32'd3);
        chk("mid_dmem_req", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state",    32'(state),    32'd0);
        chk("async_rst_pc",       32'(pc),       32'(RST_PC));
        chk("async_rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("async_rst_imem_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        pc_model = RST_PC;
        run_instr(16'h0123, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
